// File: rtl/mmio_console_if.sv
// Bus and byte-stream signals of the mmio_console device.
// master = CPU/sink side, slave = console device.
interface mmio_console_if;
  logic        enable;
  logic [31:0] addr;
  logic        rd_wr;
  logic [1:0]  access_size;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output enable, addr, rd_wr, access_size, data_in, tx_ready,
    input  data_out, tx_data, tx_valid
  );

  modport slave (
    input  enable, addr, rd_wr, access_size, data_in, tx_ready,
    output data_out, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console/exit device: byte FIFO drained on a valid/ready stream, sticky halt code.
// Optional hex-dump register enabled by defining MMIO_CONSOLE_HEX_EN.
module mmio_console #(
  parameter logic [31:0] base_addr = 32'h9000_0000,
  parameter int unsigned depth     = 16
) (
  input  logic        clk,
  input  logic        reset,
  mmio_console_if.slave bus,
  output logic        halt,
  output logic [31:0] exit_code
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic        sel;
  logic [1:0]  off;
  logic        rd_sel;
  logic        wr_sel;
  logic        tx_wr;
  logic        status_rd;
  logic        unused_addr_bits;

  assign sel       = bus.enable && (bus.access_size == 2'd0) && (bus.addr[31:4] == base_addr[31:4]);
  assign off       = bus.addr[3:2];
  assign rd_sel    = sel && bus.rd_wr;
  assign wr_sel    = sel && !bus.rd_wr;
  assign tx_wr     = wr_sel && (off == 2'd0);
  assign status_rd = rd_sel && (off == 2'd1);
  assign unused_addr_bits = ^bus.addr[1:0];

  logic [7:0]    mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [7:0]    push_byte;
  logic          cpu_push;
  logic          ovf;
  logic          set_ovf;
  logic          hex_busy;
  logic          hex_push;
  logic [7:0]    hex_byte;
  logic          hex_rej;

  assign empty        = (count == '0);
  assign full         = (count == CW'(depth));
  assign pop          = !empty && bus.tx_ready;
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = mem[rd_ptr];

`ifdef MMIO_CONSOLE_HEX_EN
  typedef enum logic {IDLE, EMIT} hex_state_t;

  hex_state_t  state;
  hex_state_t  state_n;
  logic [31:0] hex_val;
  logic [2:0]  nib_idx;
  logic [3:0]  nib;
  logic        hex_wr;

  assign hex_wr  = wr_sel && (off == 2'd3);
  assign hex_rej = hex_wr && hex_busy;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (hex_wr) state_n = EMIT;
      EMIT: if (hex_push && (nib_idx == 3'd0)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Emission stalls on a full FIFO rather than overflowing.
  always_comb begin
    hex_busy = (state == EMIT);
    hex_push = (state == EMIT) && !full;
    nib      = hex_val[{nib_idx, 2'b00} +: 4];
    hex_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_val <= '0;
      nib_idx <= '0;
    end else if ((state == IDLE) && hex_wr) begin
      hex_val <= bus.data_in;
      nib_idx <= 3'd7;
    end else if (hex_push) begin
      nib_idx <= nib_idx - 3'd1;
    end
  end
`else
  assign hex_busy = 1'b0;
  assign hex_push = 1'b0;
  assign hex_byte = '0;
  assign hex_rej  = 1'b0;
`endif

  // A full FIFO still accepts a CPU byte when the sink pops on the same edge.
  assign cpu_push  = tx_wr && !hex_busy && (!full || pop);
  assign push      = hex_push || cpu_push;
  assign push_byte = hex_push ? hex_byte : bus.data_in[7:0];
  assign set_ovf   = (tx_wr && (hex_busy || (full && !pop))) || hex_rej;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [31:0] status;

  always_comb begin
    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = ovf;
    status[3]     = hex_busy;
    status[4]     = halt;
    status[15:8]  = 8'(count);
  end

  // Read clear precedes a same-edge overflow so a fresh overflow is never lost.
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= set_ovf || (ovf && !status_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out <= '0;
    end else if (bus.enable && bus.rd_wr) begin
      bus.data_out <= status_rd ? status : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt      <= 1'b0;
      exit_code <= '0;
    end else if (wr_sel && (off == 2'd2) && !halt) begin
      halt      <= 1'b1;
      exit_code <= bus.data_in;
    end
  end
endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console against a queue-based behavioural model.
// Hex-register checks follow MMIO_CONSOLE_HEX_EN.
module tb_mmio_console;
  localparam logic [31:0] BASE  = 32'h9000_0000;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        halt;
  logic [31:0] exit_code;

  mmio_console_if ifc ();

  mmio_console #(.base_addr(BASE), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc.slave),
    .halt      (halt),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural model: stored bytes, pending hex characters, flags.
  logic [7:0]  q[$];
  logic [7:0]  hex_q[$];
  logic [7:0]  rx_log[$];
  bit          m_ovf   = 0;
  bit          m_halt  = 0;
  logic [31:0] m_code  = 0;
  logic [31:0] exp_dout = 0;
  bit          mon_en  = 0;

  function automatic logic [7:0] hexchar(input logic [3:0] n);
    return (n < 4'd10) ? 8'd48 + 8'(n) : 8'd87 + 8'(n);
  endfunction

  always @(posedge clk) begin
    int unsigned cnt;
    bit m_full, m_pop, m_busy, msel;
    logic [1:0]  moff;
    logic [31:0] st;
    if (reset) begin
      q.delete();
      hex_q.delete();
      m_ovf = 0; m_halt = 0; m_code = 0; exp_dout = 0;
    end else begin
      cnt    = q.size();
      m_full = (cnt == DEPTH);
      m_pop  = ifc.tx_ready && (cnt != 0);
      m_busy = (hex_q.size() != 0);
      msel   = ifc.enable && (ifc.access_size == 2'd0) && ((ifc.addr & 32'hFFFF_FFF0) == BASE);
      moff   = ifc.addr[3:2];
      st     = {16'h0, 8'(cnt), 3'b000, m_halt, m_busy, m_ovf, m_full, (cnt == 0)};
      if (ifc.enable && ifc.rd_wr) begin
        exp_dout = (msel && moff == 2'd1) ? st : 32'h0;
        if (msel && moff == 2'd1) m_ovf = 0;
      end
      if (m_pop) void'(q.pop_front());
      if (m_busy && !m_full) q.push_back(hex_q.pop_front());
      if (msel && !ifc.rd_wr) begin
        case (moff)
          2'd0: if (m_busy || (m_full && !m_pop)) m_ovf = 1; else q.push_back(ifc.data_in[7:0]);
          2'd2: if (!m_halt) begin m_halt = 1; m_code = ifc.data_in; end
`ifdef MMIO_CONSOLE_HEX_EN
          2'd3: if (m_busy) m_ovf = 1;
                else for (int i = 7; i >= 0; i--) hex_q.push_back(hexchar(ifc.data_in[i*4 +: 4]));
`endif
          default: ;
        endcase
      end
    end
  end

  // Stream monitor: occupancy and head byte against the model, logs accepted bytes.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk_cnt++;
      if (ifc.tx_valid !== (q.size() != 0))
        $display("FAIL tx_valid got %b exp %b t=%0t", ifc.tx_valid, (q.size() != 0), $time);
      else pass_cnt++;
      if (q.size() != 0) begin
        chk_cnt++;
        if (ifc.tx_data !== q[0]) $display("FAIL tx_data got %h exp %h t=%0t", ifc.tx_data, q[0], $time);
        else pass_cnt++;
      end
      if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) rx_log.push_back(ifc.tx_data);
    end
  end

  task automatic acc(input bit en, input bit rw, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] d);
    @(negedge clk);
    ifc.enable = en; ifc.rd_wr = rw; ifc.addr = a; ifc.access_size = sz; ifc.data_in = d;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    acc(1'b1, 1'b0, BASE + {28'h0, off, 2'b00}, 2'd0, d);
  endtask

  task automatic rd(input logic [1:0] off);
    acc(1'b1, 1'b1, BASE + {28'h0, off, 2'b00}, 2'd0, 32'h0);
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic check_dout(input string name);
    chk_cnt++;
    if (ifc.data_out !== exp_dout) $display("FAIL %s data_out got %h exp %h", name, ifc.data_out, exp_dout);
    else pass_cnt++;
  endtask

  task automatic wait_drain();
    int unsigned n;
    ifc.tx_ready = 1'b1;
    n = 0;
    while (ifc.tx_valid !== 1'b0 && n < 4 * DEPTH + 50) begin
      idle();
      n++;
    end
    idle();
    chk_cnt++;
    if (ifc.tx_valid !== 1'b0) $display("FAIL drain_timeout tx_valid got %b exp 0", ifc.tx_valid);
    else pass_cnt++;
  endtask

  task automatic check_reset_state();
    chk_cnt++;
    if (ifc.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", ifc.tx_valid); else pass_cnt++;
    chk_cnt++;
    if (halt !== 1'b0) $display("FAIL reset_halt got %b exp 0", halt); else pass_cnt++;
    chk_cnt++;
    if (exit_code !== 32'h0) $display("FAIL reset_exit_code got %h exp 0", exit_code); else pass_cnt++;
    chk_cnt++;
    if (ifc.data_out !== 32'h0) $display("FAIL reset_data_out got %h exp 0", ifc.data_out); else pass_cnt++;
    rd(2'd1);
    idle();
    check_dout("reset_status");
    chk_cnt++;
    if (ifc.data_out !== 32'h1) $display("FAIL reset_status_const got %h exp 00000001", ifc.data_out);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.tx_ready = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1;
    check_reset_state();
  endtask

  task automatic test_stream();
    ifc.tx_ready = 1'b1;
    rx_log.delete();
    wr(2'd0, 32'h41);
    wr(2'd0, 32'h42);
    chk_cnt++;
    if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'h41)
      $display("FAIL stream_first got v=%b d=%h exp v=1 d=41", ifc.tx_valid, ifc.tx_data);
    else pass_cnt++;
    idle();
    chk_cnt++;
    if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'h42)
      $display("FAIL stream_second got v=%b d=%h exp v=1 d=42", ifc.tx_valid, ifc.tx_data);
    else pass_cnt++;
    idle();
    chk_cnt++;
    if (ifc.tx_valid !== 1'b0) $display("FAIL stream_end tx_valid got %b exp 0", ifc.tx_valid);
    else pass_cnt++;
    idle();
    chk_cnt++;
    if (rx_log.size() != 2 || rx_log[0] !== 8'h41 || rx_log[1] !== 8'h42)
      $display("FAIL stream_log got size %0d exp 2 bytes 41 42", rx_log.size());
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    ifc.tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) wr(2'd0, $urandom);
    rd(2'd1);
    idle();
    check_dout("ovf_status1");
    chk_cnt++;
    if (ifc.data_out[1] !== 1'b1 || ifc.data_out[2] !== 1'b1 || ifc.data_out[15:8] !== 8'(DEPTH))
      $display("FAIL ovf_status1_fields got %h exp full=1 ovf=1 count=%0d", ifc.data_out, DEPTH);
    else pass_cnt++;
    rd(2'd1);
    idle();
    check_dout("ovf_status2");
    chk_cnt++;
    if (ifc.data_out[2] !== 1'b0) $display("FAIL ovf_cleared got %b exp 0", ifc.data_out[2]);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    rx_log.delete();
    wr(2'd0, 32'hA5);
    ifc.tx_ready = 1'b1;
    idle();
    ifc.tx_ready = 1'b0;
    rd(2'd1);
    idle();
    check_dout("pushpop_status");
    chk_cnt++;
    if (ifc.data_out[15:8] !== 8'(DEPTH) || ifc.data_out[2] !== 1'b0 || ifc.data_out[1] !== 1'b1)
      $display("FAIL pushpop_fields got %h exp count=%0d ovf=0 full=1", ifc.data_out, DEPTH);
    else pass_cnt++;
    wait_drain();
    chk_cnt++;
    if (rx_log.size() != DEPTH + 1 || rx_log[rx_log.size()-1] !== 8'hA5)
      $display("FAIL pushpop_order got size %0d exp %0d ending a5", rx_log.size(), DEPTH + 1);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    ifc.tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) wr(2'd0, $urandom);
    rd(2'd0);
    idle();
    check_dout("txdata_read");
    acc(1'b1, 1'b1, BASE + 32'h4, 2'd2, 32'h0);
    idle();
    check_dout("bad_size_read");
    chk_cnt++;
    if (ifc.data_out !== 32'h0) $display("FAIL bad_size_read_zero got %h exp 0", ifc.data_out); else pass_cnt++;
    acc(1'b1, 1'b1, BASE + 32'h14, 2'd0, 32'h0);
    idle();
    check_dout("outside_read");
    chk_cnt++;
    if (ifc.data_out !== 32'h0) $display("FAIL outside_read_zero got %h exp 0", ifc.data_out); else pass_cnt++;
    acc(1'b1, 1'b0, BASE + 32'h8, 2'd2, 32'h99);
    acc(1'b1, 1'b0, BASE + 32'h18, 2'd0, 32'h99);
    rd(2'd1);
    idle();
    check_dout("decode_status");
    chk_cnt++;
    if (ifc.data_out[2] !== 1'b1 || ifc.data_out[4] !== 1'b0 || ifc.data_out[15:8] !== 8'(DEPTH))
      $display("FAIL decode_side_effects got %h exp ovf=1 halt=0 count=%0d", ifc.data_out, DEPTH);
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_random();
    int unsigned op;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check_dout("rand_dout");
      op = $urandom_range(0, 9);
      ifc.tx_ready = ($urandom_range(0, 2) == 0);
      ifc.enable = 1'b1; ifc.access_size = 2'd0; ifc.data_in = $urandom;
      if (op < 5)      begin ifc.rd_wr = 1'b0; ifc.addr = BASE; end
      else if (op < 7) begin ifc.rd_wr = 1'b1; ifc.addr = BASE + 32'h4; end
      else if (op < 8) begin ifc.rd_wr = 1'b1; ifc.addr = BASE; end
      else             begin ifc.enable = 1'b0; ifc.rd_wr = 1'b0; end
    end
    wait_drain();
    rd(2'd1);
    idle();
    check_dout("rand_final_status");
  endtask

  task automatic test_hex();
`ifdef MMIO_CONSOLE_HEX_EN
    logic [7:0] exp_b;
    string s;
    bit bad;
    s = "deadbeef";
    ifc.tx_ready = 1'b1;
    rx_log.delete();
    wr(2'd3, 32'hDEADBEEF);
    rd(2'd1);
    idle();
    check_dout("hex_status1");
    chk_cnt++;
    if (ifc.data_out[3] !== 1'b1) $display("FAIL hex_busy1 got %b exp 1", ifc.data_out[3]); else pass_cnt++;
    wr(2'd0, 32'h55);
    rd(2'd1);
    idle();
    check_dout("hex_status2");
    chk_cnt++;
    if (ifc.data_out[3] !== 1'b1 || ifc.data_out[2] !== 1'b1)
      $display("FAIL hex_busy_ovf got %h exp busy=1 ovf=1", ifc.data_out);
    else pass_cnt++;
    repeat (10) idle();
    wait_drain();
    bad = (rx_log.size() != 8);
    for (int i = 0; i < 8 && !bad; i++) begin
      exp_b = s[i];
      if (rx_log[i] !== exp_b) bad = 1;
    end
    chk_cnt++;
    if (bad) $display("FAIL hex_string got %0d bytes exp \"deadbeef\"", rx_log.size()); else pass_cnt++;
    rd(2'd1);
    idle();
    check_dout("hex_status3");
    chk_cnt++;
    if (ifc.data_out[3] !== 1'b0) $display("FAIL hex_idle got %b exp 0", ifc.data_out[3]); else pass_cnt++;
`else
    rx_log.delete();
    ifc.tx_ready = 1'b1;
    wr(2'd3, 32'hDEADBEEF);
    repeat (3) idle();
    chk_cnt++;
    if (rx_log.size() != 0) $display("FAIL hex_ignored got %0d bytes exp 0", rx_log.size()); else pass_cnt++;
    rd(2'd1);
    idle();
    check_dout("hex_off_status");
    chk_cnt++;
    if (ifc.data_out !== 32'h1) $display("FAIL hex_off_status_const got %h exp 00000001", ifc.data_out);
    else pass_cnt++;
`endif
  endtask

  task automatic test_exit();
    ifc.tx_ready = 1'b0;
    rx_log.delete();
    for (int i = 0; i < 3; i++) wr(2'd0, $urandom);
    wr(2'd2, 32'd7);
    wr(2'd2, 32'd9);
    idle();
    chk_cnt++;
    if (halt !== 1'b1 || halt !== m_halt) $display("FAIL exit_halt got %b exp 1", halt); else pass_cnt++;
    chk_cnt++;
    if (exit_code !== 32'd7 || exit_code !== m_code) $display("FAIL exit_code got %0d exp 7", exit_code);
    else pass_cnt++;
    wait_drain();
    chk_cnt++;
    if (rx_log.size() != 3) $display("FAIL exit_drain got %0d bytes exp 3", rx_log.size()); else pass_cnt++;
    ifc.tx_ready = 1'b0;
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check_reset_state();
  endtask

  initial begin
    reset = 1'b1;
    ifc.enable = 1'b0; ifc.rd_wr = 1'b0; ifc.addr = '0; ifc.access_size = '0; ifc.data_in = '0;
    ifc.tx_ready = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_push_pop_full();
    test_decode();
    test_random();
    test_hex();
    test_exit();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
